// File: rtl/inst_encode_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_encode_loader_if
// Description : Field-beat stream, instruction-memory write port and session
//               status of the instruction encoder/loader, bundled as one
//               interface.
//               slave  : the loader (consumes beats, drives memory/status)
//               master : the program source (drives beats, observes outputs)
//               Beat   : start, finish, in_valid/in_ready, fmt, funct3,
//                        funct7, rd, rs1, rs2, imm
//               Memory : mem_we, mem_addr, mem_wdata
//               Status : count, full, busy, done, err
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_encode_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              finish;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [31:0]       imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  start, finish, in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm,
      output in_ready, mem_we, mem_addr, mem_wdata, count, full, busy, done, err
   );

   modport master (
      output start, finish, in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, full, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_encode_loader
// Description : Packs RV32I R / I-ALU / I-load / S instruction fields into
//               32-bit words and writes them to consecutive instruction-memory
//               addresses starting at 0 for each load session.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               ld_if  - inst_encode_loader_if.slave (beat stream in,
//                        memory write port and session status out)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encode_loader #(
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   inst_encode_loader_if.slave   ld_if
);

   localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [6:0]      OP_R    = 7'b0110011;
   localparam logic [6:0]      OP_IALU = 7'b0010011;
   localparam logic [6:0]      OP_LOAD = 7'b0000011;
   localparam logic [6:0]      OP_S    = 7'b0100011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [ADDR_W:0]   count_q,     count_d;
   logic              err_q,       err_d;

   logic        full;
   logic        ready;
   logic        accept;
   logic        is_shift;
   logic        simm_ok;
   logic        imm_ok;
   logic [31:0] enc_word;

   assign full   = (count_q == CAP);
   assign ready  = (state_q == LOAD) && !full;
   assign accept = ld_if.in_valid && ready;

   // Encoder and immediate range check
   always_comb begin
      enc_word = '0;
      imm_ok   = 1'b1;
      is_shift = (ld_if.funct3 == 3'b001) || (ld_if.funct3 == 3'b101);
      // imm[31:11] all-equal means the value fits a 12-bit signed field
      simm_ok  = (&ld_if.imm[31:11]) || !(|ld_if.imm[31:11]);
      case (ld_if.fmt)
         2'b00: begin
            enc_word = {ld_if.funct7, ld_if.rs2, ld_if.rs1, ld_if.funct3,
                        ld_if.rd, OP_R};
         end
         2'b01: begin
            if (is_shift) begin
               // Shifts carry funct7 in the top bits and a 5-bit shamt
               enc_word = {ld_if.funct7, ld_if.imm[4:0], ld_if.rs1,
                           ld_if.funct3, ld_if.rd, OP_IALU};
               imm_ok   = !(|ld_if.imm[31:5]);
            end else begin
               enc_word = {ld_if.imm[11:0], ld_if.rs1, ld_if.funct3,
                           ld_if.rd, OP_IALU};
               imm_ok   = simm_ok;
            end
         end
         2'b10: begin
            enc_word = {ld_if.imm[11:0], ld_if.rs1, ld_if.funct3,
                        ld_if.rd, OP_LOAD};
            imm_ok   = simm_ok;
         end
         default: begin
            enc_word = {ld_if.imm[11:5], ld_if.rs2, ld_if.rs1, ld_if.funct3,
                        ld_if.imm[4:0], OP_S};
            imm_ok   = simm_ok;
         end
      endcase
   end

   // Next-state logic. The write strobe, address and data are registered in
   // the accept cycle, and count advances on the same edge, so a visible
   // write always shows the pre-increment count on mem_addr.
   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      count_d     = count_q;
      err_d       = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (ld_if.start) begin
               state_d = LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               if (imm_ok) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = count_q[ADDR_W-1:0];
                  mem_wdata_d = enc_word;
                  count_d     = count_q + (ADDR_W+1)'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            if (ld_if.finish) begin
               // A good beat taken alongside finish still owes its write
               state_d = (accept && imm_ok) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign ld_if.in_ready  = ready;
   assign ld_if.mem_we    = mem_we_q;
   assign ld_if.mem_addr  = mem_addr_q;
   assign ld_if.mem_wdata = mem_wdata_q;
   assign ld_if.count     = count_q;
   assign ld_if.full      = full;
   assign ld_if.busy      = (state_q == LOAD) || (state_q == DRAIN);
   assign ld_if.done      = (state_q == DONE);
   assign ld_if.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encode_loader
// Description : Directed self-checking bench for inst_encode_loader. Instance
//               a uses ADDR_W=8, instance b uses ADDR_W=2 for the full case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encode_loader;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   inst_encode_loader_if #(.ADDR_W(8)) a ();
   inst_encode_loader_if #(.ADDR_W(2)) b ();

   inst_encode_loader #(.ADDR_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .ld_if(a));
   inst_encode_loader #(.ADDR_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .ld_if(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic beat_a(input logic [1:0] f, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd_v, input logic [4:0] rs1_v,
                         input logic [4:0] rs2_v, input logic [31:0] im);
      a.fmt = f; a.funct3 = f3; a.funct7 = f7; a.rd = rd_v;
      a.rs1 = rs1_v; a.rs2 = rs2_v; a.imm = im; a.in_valid = 1'b1;
   endtask

   task automatic start_a();
      @(negedge clk); a.start = 1'b1;
      @(negedge clk); a.start = 1'b0;
   endtask

   task automatic finish_a();
      @(negedge clk); a.finish = 1'b1;
      @(negedge clk); a.finish = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      n_cmp++; if (a.in_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_in_ready got %b exp 0", a.in_ready); end
      n_cmp++; if (a.mem_we !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_we got %b exp 0", a.mem_we); end
      n_cmp++; if (a.mem_addr !== 8'h00)  begin n_bad++; $display("FAIL rst_mem_addr got %h exp 00", a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata got %h exp 0", a.mem_wdata); end
      n_cmp++; if (a.count !== 9'd0)      begin n_bad++; $display("FAIL rst_count got %0d exp 0", a.count); end
      n_cmp++; if ({a.full, a.busy, a.done, a.err} !== 4'b0000)
         begin n_bad++; $display("FAIL rst_status got %b exp 0000", {a.full, a.busy, a.done, a.err}); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (a.in_ready !== 1'b0)   begin n_bad++; $display("FAIL idle_in_ready got %b exp 0", a.in_ready); end
   endtask

   task automatic test_r_beat();
      start_a();
      n_cmp++; if (a.in_ready !== 1'b1) begin n_bad++; $display("FAIL r_in_ready got %b exp 1", a.in_ready); end
      n_cmp++; if (a.busy !== 1'b1)     begin n_bad++; $display("FAIL r_busy got %b exp 1", a.busy); end
      beat_a(2'b00, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
      @(negedge clk); a.in_valid = 1'b0;
      n_cmp++; if (a.mem_we !== 1'b1)           begin n_bad++; $display("FAIL r_we got %b exp 1", a.mem_we); end
      n_cmp++; if (a.mem_addr !== 8'd0)         begin n_bad++; $display("FAIL r_addr got %h exp 00", a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL r_wdata got %h exp 002081b3", a.mem_wdata); end
      n_cmp++; if (a.count !== 9'd1)            begin n_bad++; $display("FAIL r_count got %0d exp 1", a.count); end
      @(negedge clk);
      n_cmp++; if (a.mem_we !== 1'b0)           begin n_bad++; $display("FAIL r_we_pulse got %b exp 0", a.mem_we); end
      n_cmp++; if (a.mem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL r_wdata_hold got %h exp 002081b3", a.mem_wdata); end
      finish_a();
      n_cmp++; if ({a.done, a.busy} !== 2'b10) begin n_bad++; $display("FAIL r_done got %b exp 10", {a.done, a.busy}); end
   endtask

   task automatic test_back_to_back();
      start_a();
      n_cmp++; if ({a.done, a.busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_restart got %b exp 01", {a.done, a.busy}); end
      n_cmp++; if (a.count !== 9'd0)           begin n_bad++; $display("FAIL b2b_count0 got %0d exp 0", a.count); end
      beat_a(2'b01, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.mem_addr} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL b2b_w0 got %b/%h exp 1/00", a.mem_we, a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'hFFF00293) begin n_bad++; $display("FAIL b2b_wdata0 got %h exp fff00293", a.mem_wdata); end
      beat_a(2'b11, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      @(negedge clk); a.in_valid = 1'b0;
      n_cmp++; if ({a.mem_we, a.mem_addr} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL b2b_w1 got %b/%h exp 1/01", a.mem_we, a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h0020A423) begin n_bad++; $display("FAIL b2b_wdata1 got %h exp 0020a423", a.mem_wdata); end
      n_cmp++; if (a.count !== 9'd2)             begin n_bad++; $display("FAIL b2b_count got %0d exp 2", a.count); end
      finish_a();
   endtask

   task automatic test_range_err();
      start_a();
      beat_a(2'b01, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.err} !== 2'b01) begin n_bad++; $display("FAIL err_bad got we/err %b exp 01", {a.mem_we, a.err}); end
      n_cmp++; if (a.count !== 9'd0)            begin n_bad++; $display("FAIL err_count got %0d exp 0", a.count); end
      beat_a(2'b01, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.mem_addr, a.err} !== {1'b1, 8'd0, 1'b1})
         begin n_bad++; $display("FAIL err_good got we/addr/err %b/%h/%b exp 1/00/1", a.mem_we, a.mem_addr, a.err); end
      n_cmp++; if (a.mem_wdata !== 32'h00400093) begin n_bad++; $display("FAIL err_good_wdata got %h exp 00400093", a.mem_wdata); end
      beat_a(2'b01, 3'b001, 7'd0, 5'd2, 5'd1, 5'd0, 32'd32);
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.count} !== {1'b0, 9'd1}) begin n_bad++; $display("FAIL shift_bad got we/count %b/%0d exp 0/1", a.mem_we, a.count); end
      beat_a(2'b01, 3'b001, 7'd0, 5'd2, 5'd1, 5'd0, 32'd3);
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.mem_addr} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL slli_addr got %b/%h exp 1/01", a.mem_we, a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h00309113) begin n_bad++; $display("FAIL slli_wdata got %h exp 00309113", a.mem_wdata); end
      beat_a(2'b01, 3'b101, 7'h20, 5'd2, 5'd1, 5'd0, 32'd3);
      @(negedge clk);
      n_cmp++; if (a.mem_wdata !== 32'h4030D113) begin n_bad++; $display("FAIL srai_wdata got %h exp 4030d113", a.mem_wdata); end
      beat_a(2'b10, 3'b010, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFFFF800);
      @(negedge clk); a.in_valid = 1'b0;
      n_cmp++; if ({a.mem_we, a.mem_addr} !== {1'b1, 8'd3}) begin n_bad++; $display("FAIL load_addr got %b/%h exp 1/03", a.mem_we, a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h80012203) begin n_bad++; $display("FAIL load_wdata got %h exp 80012203", a.mem_wdata); end
      n_cmp++; if (a.err !== 1'b1)               begin n_bad++; $display("FAIL err_sticky got %b exp 1", a.err); end
      finish_a();
      n_cmp++; if (a.err !== 1'b1)               begin n_bad++; $display("FAIL err_in_done got %b exp 1", a.err); end
      start_a();
      n_cmp++; if ({a.err, a.count} !== {1'b0, 9'd0}) begin n_bad++; $display("FAIL err_clear got err/count %b/%0d exp 0/0", a.err, a.count); end
   endtask

   task automatic test_drain();
      // a is in LOAD from the previous start
      beat_a(2'b00, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 32'h0);
      a.finish = 1'b1;
      @(negedge clk); a.finish = 1'b0; a.in_valid = 1'b0;
      n_cmp++; if ({a.busy, a.done, a.in_ready} !== 3'b100) begin n_bad++; $display("FAIL drain_state got busy/done/rdy %b exp 100", {a.busy, a.done, a.in_ready}); end
      n_cmp++; if ({a.mem_we, a.mem_addr} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL drain_we got %b/%h exp 1/00", a.mem_we, a.mem_addr); end
      n_cmp++; if (a.mem_wdata !== 32'h000003B3) begin n_bad++; $display("FAIL drain_wdata got %h exp 000003b3", a.mem_wdata); end
      @(negedge clk);
      n_cmp++; if ({a.done, a.busy, a.mem_we} !== 3'b100) begin n_bad++; $display("FAIL drain_done got done/busy/we %b exp 100", {a.done, a.busy, a.mem_we}); end
   endtask

   task automatic test_full();
      @(negedge clk); b.start = 1'b1;
      @(negedge clk); b.start = 1'b0;
      b.fmt = 2'b00; b.funct3 = 3'b000; b.funct7 = 7'd0; b.rs1 = 5'd0; b.rs2 = 5'd0; b.imm = 32'h0;
      b.rd = 5'd1; b.in_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_cmp++; if ({b.mem_we, b.mem_addr} !== {1'b1, 2'(k - 1)})
            begin n_bad++; $display("FAIL full_w%0d got we/addr %b/%0d exp 1/%0d", k, b.mem_we, b.mem_addr, k - 1); end
         n_cmp++; if (b.mem_wdata !== ((32'(k) << 7) | 32'h33))
            begin n_bad++; $display("FAIL full_wdata%0d got %h exp %h", k, b.mem_wdata, (32'(k) << 7) | 32'h33); end
         b.rd = 5'(k + 1);
      end
      n_cmp++; if ({b.full, b.in_ready, b.count} !== {1'b1, 1'b0, 3'd4})
         begin n_bad++; $display("FAIL full_flag got full/rdy/count %b/%b/%0d exp 1/0/4", b.full, b.in_ready, b.count); end
      @(negedge clk);
      n_cmp++; if ({b.mem_we, b.count} !== {1'b0, 3'd4}) begin n_bad++; $display("FAIL full_no5th got we/count %b/%0d exp 0/4", b.mem_we, b.count); end
      b.in_valid = 1'b0; b.finish = 1'b1;
      @(negedge clk); b.finish = 1'b0;
      n_cmp++; if ({b.done, b.busy, b.count} !== {1'b1, 1'b0, 3'd4})
         begin n_bad++; $display("FAIL full_done got done/busy/count %b/%b/%0d exp 1/0/4", b.done, b.busy, b.count); end
      n_cmp++; if (b.mem_addr !== 2'd3) begin n_bad++; $display("FAIL full_addr_hold got %0d exp 3", b.mem_addr); end
   endtask

   task automatic test_reset_mid();
      start_a();
      beat_a(2'b00, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0);
      @(negedge clk); a.rd = 5'd2;
      @(negedge clk); a.rd = 5'd3;
      n_cmp++; if ({a.mem_we, a.count} !== {1'b1, 9'd2}) begin n_bad++; $display("FAIL rm_pre got we/count %b/%0d exp 1/2", a.mem_we, a.count); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({a.mem_we, a.busy, a.in_ready, a.done, a.err, a.full} !== 6'b0)
         begin n_bad++; $display("FAIL rm_async got %b exp 000000", {a.mem_we, a.busy, a.in_ready, a.done, a.err, a.full}); end
      n_cmp++; if ({a.count, a.mem_addr, a.mem_wdata} !== '0)
         begin n_bad++; $display("FAIL rm_async_bus got count/addr/wdata %0d/%h/%h exp 0", a.count, a.mem_addr, a.mem_wdata); end
      @(negedge clk);
      n_cmp++; if (a.mem_we !== 1'b0) begin n_bad++; $display("FAIL rm_nowrite got %b exp 0", a.mem_we); end
      rst_n = 1'b1; a.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({a.mem_we, a.busy, a.done} !== 3'b000) begin n_bad++; $display("FAIL rm_idle got we/busy/done %b exp 000", {a.mem_we, a.busy, a.done}); end
      start_a();
      beat_a(2'b00, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0);
      @(negedge clk); a.in_valid = 1'b0;
      n_cmp++; if ({a.mem_we, a.mem_addr, a.count} !== {1'b1, 8'd0, 9'd1})
         begin n_bad++; $display("FAIL rm_restart got we/addr/count %b/%h/%0d exp 1/00/1", a.mem_we, a.mem_addr, a.count); end
      n_cmp++; if (a.mem_wdata !== 32'h000002B3) begin n_bad++; $display("FAIL rm_restart_wdata got %h exp 000002b3", a.mem_wdata); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0;
      a.start = 1'b0; a.finish = 1'b0; a.in_valid = 1'b0; a.fmt = 2'b00; a.funct3 = 3'b0;
      a.funct7 = 7'b0; a.rd = 5'b0; a.rs1 = 5'b0; a.rs2 = 5'b0; a.imm = 32'h0;
      b.start = 1'b0; b.finish = 1'b0; b.in_valid = 1'b0; b.fmt = 2'b00; b.funct3 = 3'b0;
      b.funct7 = 7'b0; b.rd = 5'b0; b.rs1 = 5'b0; b.rs2 = 5'b0; b.imm = 32'h0;
      test_reset();
      test_r_beat();
      test_back_to_back();
      test_range_err();
      test_drain();
      test_full();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Encoder-side counterpart of the core's immediate/instruction decode path.
- Accepts instruction fields (format, register indices, functs, 32-bit signed immediate) over a valid/ready stream.
- Packs them into RV32I R, I-ALU, I-load and S encodings.
- Writes the packed words sequentially into the instruction-memory write port. It is used by the bench and boot loader to build programs for the single-cycle core.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address. Capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse: begin a load session at address 0.
- finish  input  1  pulse: end the load session.
- in_valid  input  1  field beat valid.
- in_ready  output  1  encoder can accept a beat.
- fmt  input  2  00 R, 01 I-ALU, 10 I-load, 11 S.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R; I-ALU shifts only).
- rd  input  5  destination register (ignored for S).
- rs1  input  5  source register 1.
- rs2  input  5  source register 2 (R, S only).
- imm  input  32  signed immediate (ignored for R).
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  number of words written this session.
- full  output  1  count == 2**ADDR_W.
- busy  output  1  session in progress.
- done  output  1  session finished, held until the next start.
- err  output  1  sticky: an immediate was out of range.

Behaviour:
- Reset (async, rst_n=0) forces immediately: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, busy=0, done=0, err=0. Reset mid-session abandons any pending write; no write strobe is issued.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE --start--> LOAD. count=0 and err=0 on entry.
  - LOAD --finish--> DRAIN if a write is pending, else straight to DONE.
  - DRAIN --pending write issued--> DONE.
  - DONE --start--> LOAD. Restarts at address 0 and clears count and err. done drops on this transition.
  - start is ignored in LOAD and DRAIN. finish is ignored in IDLE and DONE.
- busy=1 in LOAD and DRAIN.
- in_ready = (state==LOAD) && !full. It is combinational from registered state.
- Accept condition: in_valid && in_ready. A beat accepted in the same cycle as finish is still encoded and written.
- Latency: the word is encoded in the accept cycle and registered. mem_we=1 for exactly one cycle on the next cycle, with mem_addr = count (pre-increment) and mem_wdata = the word. count increments in that same cycle. Back-to-back accepts give one write per cycle.
- Encodings, bit ranges given msb to lsb:
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] 0110011.
  - I-ALU: imm[11:0][31:20] rs1 funct3 rd 0010011.
  - I-ALU with funct3=001 or 101 (shift): [31:25]=funct7, [24:20]=imm[4:0].
  - I-load: imm[11:0][31:20] rs1 funct3 rd 0000011.
  - S: imm[11:5][31:25] rs2 rs1 funct3 imm[4:0][11:7] 0100011.
- Range checks:
  - I-ALU (non-shift), I-load and S require imm[31:11] to be all-equal (12-bit signed).
  - Shifts require imm[31:5]==0.
  - R is never checked.
- A failing beat is still accepted (handshake completes). No mem_we is issued, count is unchanged, err is set and stays set until the next start. The next good beat is written at the same address.
- Full: after the 2**ADDR_W-th write, full=1 and in_ready=0. A held in_valid is not accepted. finish still moves to DONE. No address wrap-around ever occurs.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- done=1 only in DONE.

Test Plan:
- start; R beat funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x002081B3, count=1.
- I-ALU beat rd=5, rs1=0, funct3=0, imm=0xFFFFFFFF, back-to-back with an S beat rs2=2, rs1=1, funct3=010, imm=8 -> writes 0xFFF00293 at addr 0 and 0x0020A423 at addr 1 on consecutive cycles, count=2.
- I-ALU beat imm=2048, then a valid beat with imm=4 -> err=1, no write for the first beat, second beat written at addr 0, err still 1. A following start clears err.
- ADDR_W=2, five beats with valid held high -> four writes at addrs 0..3. Then full=1, in_ready=0, and the fifth beat is not accepted. finish -> done=1, count=4.
- Beat accepted in the same cycle as finish -> state goes to DRAIN, the write occurs next cycle, done=1 the cycle after, busy=0.
- rst_n low for 1 cycle mid-stream after 2 writes, with a write pending -> all outputs 0 asynchronously, no further mem_we, state IDLE. A subsequent start writes from addr 0.
